spi_serf: RTL
=============

# spi_serf

Synthesizable SPI serf (responder) that sits on the system clock domain and answers 16-bit frames from the SPI monarch. Each frame is a command byte followed by a data byte. Reads expose a 7-bit address to a local register file and return its 8-bit data on MISO. Writes present the address and data to the register file at end of frame. Used as the on-chip register endpoint for any block reached over the monarch's SPI link, and as the RTL counterpart to the behavioral serf models used in benches.

## Interface
- Parameters: none. Frame length fixed at 16 bits. Mode fixed at SPI mode 3 (SCLK idles high).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- SS_n  in  1  serf select from monarch, asynchronous to clk.
- SCLK  in  1  serial clock from monarch, asynchronous to clk.
- MOSI  in  1  serial data from monarch, MSB first.
- MISO  out  1  serial data to monarch, MSB first.
- MISO_en  out  1  high while the synchronized SS_n is low; enables the external tristate.
- reg_addr  out  7  frame bits 14:8, held from capture until the next frame's capture.
- reg_rd_req  out  1  one-clk pulse when a read command (bit 15 = 1) has been received.
- reg_rd_data  in  8  register read data; must be valid on the clk after reg_rd_req.
- reg_wr  out  1  one-clk pulse at the end of a valid write frame (bit 15 = 0).
- reg_wr_data  out  8  frame bits 7:0 of the last valid frame.
- rx_data  out  16  full received frame, updated at end of a valid frame.
- done  out  1  one-clk pulse at the end of any valid 16-bit frame.
- frm_err  out  1  one-clk pulse at the end of a malformed frame.

## Operation
- Synchronizers: SS_n, SCLK and MOSI each pass through 2 flops. A third flop on SCLK and SS_n supports edge detection. SS_n and SCLK sync flops reset to 1. MOSI sync flops reset to 0.
- FSM has two states: IDLE and SHIFT.
  - IDLE -> SHIFT on synchronized SS_n fall. On entry: bit count = 0, tx shift = 16'h0000, MISO = 0.
  - SHIFT -> IDLE on synchronized SS_n rise.
  - If bit count == 16 at SS_n rise: pulse done, load rx_data, load reg_wr_data from bits 7:0, and pulse reg_wr if bit 15 == 0.
  - Otherwise: pulse frm_err only. No done, no reg_wr, and rx_data is unchanged.
- SCLK rise (in SHIFT): shift synchronized MOSI into the rx shift LSB. Bit count increments and saturates at 17. If the count reaches 17, the frame is malformed.
- SCLK fall (in SHIFT): MISO <= tx_shift[15], then tx_shift <<= 1. The monarch samples on rises, so fall n (n = 1..16) presents frame bit 16-n.
- After rise 8: reg_addr <= rx bits 6:0 (frame 14:8). If rx bit 7 == 1, pulse reg_rd_req on the following clk.
- On the clk after reg_rd_req, load the tx shift with reg_rd_data. Because 8 bits have already shifted out, these bits go out on falls 9..16. For writes, bits 7:0 go out as 0.
- Returned frame: upper byte 8'h00, lower byte the register data.
- SCLK edges while in IDLE are ignored.
- Reset mid-frame: all outputs return to reset values immediately and the FSM goes to IDLE. No done, reg_wr or frm_err is issued for the interrupted frame.
- A new SS_n fall while in SHIFT cannot occur (SS_n rise is required first).

## Timing
- Reset values: MISO 0, MISO_en 0, reg_addr 0, reg_rd_req 0, reg_wr 0, reg_wr_data 0, rx_data 0, done 0, frm_err 0. FSM in IDLE.
- Pin-to-edge-detect latency is 3 clk for SS_n and SCLK. MOSI is aligned with SCLK through equal-depth sync.
- SCLK high and low phases must each be >= 4 clk. The monarch's SCLK = clk/16 meets this.
- reg_rd_req is 1 clk after the rise-8 detect. The tx load is 1 clk later. Fall 9 arrives >= 4 clk after rise 8, so read data always precedes it.
- done, reg_wr and frm_err are 1 clk after the SS_n rise detect, and are mutually exclusive except that done and reg_wr are coincident.
- MISO_en follows synchronized SS_n with 3 clk lag.
- Back-to-back frames: SS_n high for >= 4 clk between frames is sufficient.

## Test plan
- Read: monarch sends 16'h8F00 with reg_rd_data = 8'h6A. Required: reg_addr = 7'h0F, one reg_rd_req pulse, monarch rd_data = 16'h006A, one done, no reg_wr.
- Write: monarch sends 16'h0D02. Required: reg_wr pulse with reg_addr = 7'h0D and reg_wr_data = 8'h02, rx_data = 16'h0D02, done coincident with reg_wr.
- Short frame: SS_n rises after 10 SCLK rises. Required: frm_err pulse, no done, no reg_wr, rx_data unchanged.
- Long frame: 17 SCLK rises before SS_n rise. Required: frm_err pulse, no reg_wr.
- Reset mid-frame: rst_n low after 5 bits, then release, then send a 16'h8F00 frame. Required: all outputs at reset values with no pulses, then the following 16'h8F00 completes normally with rd_data 16'h006A.
- Back-to-back: 16'h0D02 then 16'h8D00 with reg_rd_data = 8'h02 and 4-clk SS_n gap. Required: reg_wr pulse, then rd_data 16'h0002, and two done pulses.

Source files
------------

// File: rtl/spi_serf.sv
// spi_serf: SPI mode-3 responder on the system clock domain.
// Takes 16-bit frames (command byte, then data byte) and bridges them to a local
// register file: reads return {8'h00, data} on MISO, writes are issued at end of frame.
module spi_serf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_en,
  output logic [6:0]  reg_addr,
  output logic        reg_rd_req,
  input  logic [7:0]  reg_rd_data,
  output logic        reg_wr,
  output logic [7:0]  reg_wr_data,
  output logic [15:0] rx_data,
  output logic        done,
  output logic        frm_err
);

  localparam int unsigned FrameBits = 16;
  localparam int unsigned CntW      = 5;
  localparam int unsigned AddrW     = 7;
  localparam int unsigned DataW     = 8;

  localparam logic [CntW-1:0] CntFull = CntW'(FrameBits);
  localparam logic [CntW-1:0] CntSat  = CntW'(FrameBits + 1);
  localparam logic [CntW-1:0] CntCmd  = CntW'(DataW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Synchronizer chains (third stage on SS_n/SCLK for edge detection)
  logic [2:0] ss_sync_q;
  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FrameBits-1:0] rx_q, rx_d;
  logic [FrameBits-1:0] tx_q, tx_d;
  logic                 miso_q, miso_d;
  logic                 miso_en_q, miso_en_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic                 rd_req_q, rd_req_d;
  logic                 rd_ld_q, rd_ld_d;
  logic                 wr_q, wr_d;
  logic [DataW-1:0]     wr_data_q, wr_data_d;
  logic [FrameBits-1:0] rx_data_q, rx_data_d;
  logic                 done_q, done_d;
  logic                 frm_err_q, frm_err_d;

  logic ss_fall_c;
  logic ss_rise_c;
  logic sclk_rise_c;
  logic sclk_fall_c;
  logic mosi_c;
  logic [FrameBits-1:0] rx_shift_c;
  logic [CntW-1:0]      cnt_inc_c;

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], SS_n};
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  // Edge detects on the synchronized pins; MOSI shares SCLK's sync depth
  always_comb begin
    ss_fall_c   = ss_sync_q[2] & ~ss_sync_q[1];
    ss_rise_c   = ~ss_sync_q[2] & ss_sync_q[1];
    sclk_rise_c = ~sclk_sync_q[2] & sclk_sync_q[1];
    sclk_fall_c = sclk_sync_q[2] & ~sclk_sync_q[1];
    mosi_c      = mosi_sync_q[1];
    rx_shift_c  = {rx_q[FrameBits-2:0], mosi_c};
    cnt_inc_c   = (cnt_q == CntSat) ? CntSat : cnt_q + CntW'(1);
  end

  // Frame FSM with shift datapath and register-file handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    miso_en_d = ~ss_sync_q[1];
    addr_d    = addr_q;
    rd_req_d  = 1'b0;
    rd_ld_d   = rd_req_q;
    wr_d      = 1'b0;
    wr_data_d = wr_data_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    frm_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall_c) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tx_d    = '0;
          miso_d  = 1'b0;
        end
      end

      SHIFT: begin
        if (ss_rise_c) begin
          state_d = IDLE;
          if (cnt_q == CntFull) begin
            done_d    = 1'b1;
            rx_data_d = rx_q;
            wr_data_d = rx_q[DataW-1:0];
            wr_d      = ~rx_q[FrameBits-1];
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          // Read data lands in the upper byte: falls 9..16 shift it out
          if (rd_ld_q) begin
            tx_d = {reg_rd_data, DataW'(0)};
          end
          if (sclk_rise_c) begin
            rx_d  = rx_shift_c;
            cnt_d = cnt_inc_c;
            if (cnt_q == CntCmd) begin
              addr_d   = rx_shift_c[AddrW-1:0];
              rd_req_d = rx_shift_c[DataW-1];
            end
          end
          if (sclk_fall_c) begin
            miso_d = tx_q[FrameBits-1];
            tx_d   = {tx_q[FrameBits-2:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      miso_en_q <= 1'b0;
      addr_q    <= '0;
      rd_req_q  <= 1'b0;
      rd_ld_q   <= 1'b0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      miso_en_q <= miso_en_d;
      addr_q    <= addr_d;
      rd_req_q  <= rd_req_d;
      rd_ld_q   <= rd_ld_d;
      wr_q      <= wr_d;
      wr_data_q <= wr_data_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign MISO        = miso_q;
  assign MISO_en     = miso_en_q;
  assign reg_addr    = addr_q;
  assign reg_rd_req  = rd_req_q;
  assign reg_wr      = wr_q;
  assign reg_wr_data = wr_data_q;
  assign rx_data     = rx_data_q;
  assign done        = done_q;
  assign frm_err     = frm_err_q;

endmodule
